// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the CPU top level:
// loader FSM state encodings and the default instruction memory depth.
package instruction_loader_pkg;

    localparam int IL_MAX_WORDS = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loaderState_t;

endpackage

// File: rtl/instruction_loader.sv
// Streams bytes from a byte source into instruction memory as big-endian words,
// holding the CPU for the duration of the load.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MAX_WORDS = IL_MAX_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] base_addr,
    input  logic [7:0]  length,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [29:0] WriteAddress,
    output logic [31:0] writeDataINS,
    output logic        writeINS,
    output logic        cpu_hold,
    output logic        done,
    output logic [7:0]  checksum
);

    // Largest length the 8-bit length port can ever request, bounded by memory depth.
    localparam logic [8:0] LEN_CAP = (MAX_WORDS > 255) ? 9'd255 : 9'(MAX_WORDS);

    loaderState_t state;
    logic [29:0]  baseReg;
    logic [7:0]   lenReg;
    logic [7:0]   wordIdx;
    logic [1:0]   byteCnt;
    logic [23:0]  shiftReg;
    logic [7:0]   capLen;

    always_comb begin
        capLen = length;
        if ({1'b0, length} > LEN_CAP) begin
            capLen = LEN_CAP[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baseReg      <= '0;
            lenReg       <= '0;
            wordIdx      <= '0;
            byteCnt      <= '0;
            shiftReg     <= '0;
            byte_ready   <= 1'b0;
            WriteAddress <= '0;
            writeDataINS <= '0;
            writeINS     <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            checksum     <= '0;
        end else begin
            writeINS <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        baseReg  <= base_addr;
                        wordIdx  <= '0;
                        byteCnt  <= '0;
                        shiftReg <= '0;
                        checksum <= '0;
                        cpu_hold <= 1'b1;
                        if (length == 8'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            lenReg     <= capLen;
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end
                    end
                end
                RECV: begin
                    // Abort wins over a byte presented in the same cycle.
                    if (abort) begin
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                        byteCnt    <= '0;
                        state      <= IDLE;
                    end else if (byte_valid && byte_ready) begin
                        checksum <= checksum ^ byte_data;
                        shiftReg <= {shiftReg[15:0], byte_data};
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            writeINS     <= 1'b1;
                            WriteAddress <= baseReg + {22'd0, wordIdx};
                            writeDataINS <= {shiftReg, byte_data};
                            byte_ready   <= 1'b0;
                            state        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        cpu_hold <= 1'b0;
                        byteCnt  <= '0;
                        state    <= IDLE;
                    end else if ((wordIdx + 8'd1) == lenReg) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wordIdx    <= wordIdx + 8'd1;
                        byte_ready <= 1'b1;
                        state      <= RECV;
                    end
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [29:0] base_addr = '0;
    logic [7:0]  length = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [29:0] WriteAddress;
    logic [31:0] writeDataINS;
    logic        writeINS;
    logic        cpu_hold;
    logic        done;
    logic [7:0]  checksum;

    int testCount = 0;
    int failCount = 0;
    int wrCount = 0;
    int doneCount = 0;
    logic [29:0] wrAddrLog[$];
    logic [31:0] wrDataLog[$];
    logic [7:0]  bq[$];

    instruction_loader #(.MAX_WORDS(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .abort        (abort),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .WriteAddress (WriteAddress),
        .writeDataINS (writeDataINS),
        .writeINS     (writeINS),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (writeINS) begin
            wrCount++;
            wrAddrLog.push_back(WriteAddress);
            wrDataLog.push_back(writeDataINS);
        end
        if (done) doneCount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        wrCount = 0;
        doneCount = 0;
        wrAddrLog.delete();
        wrDataLog.delete();
    endtask

    task automatic checkAllZero(input string tag);
        check1({tag, " byte_ready"}, byte_ready, 1'b0);
        check1({tag, " writeINS"}, writeINS, 1'b0);
        check1({tag, " cpu_hold"}, cpu_hold, 1'b0);
        check1({tag, " done"}, done, 1'b0);
        check({tag, " checksum"}, {24'd0, checksum}, 32'd0);
        check({tag, " WriteAddress"}, {2'd0, WriteAddress}, 32'd0);
        check({tag, " writeDataINS"}, writeDataINS, 32'd0);
    endtask

    task automatic startLoad(input logic [29:0] base, input logic [7:0] len);
        base_addr = base;
        length = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input int unsigned gap, input logic expWr,
                            input logic [29:0] expAddr, input logic [31:0] expData);
        int unsigned guard = 0;
        byte_valid = 1'b1;
        byte_data = d;
        while (byte_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check1("byte_ready wait", (guard < 20), 1'b1);
        tick();
        byte_valid = 1'b0;
        byte_data = '0;
        check1("writeINS after byte", writeINS, expWr);
        if (expWr) begin
            check("WriteAddress", {2'd0, WriteAddress}, {2'd0, expAddr});
            check("writeDataINS", writeDataINS, expData);
            check1("byte_ready in WRITE", byte_ready, 1'b0);
        end
        for (int unsigned g = 0; g < gap; g++) begin
            tick();
            check1("writeINS idle", writeINS, 1'b0);
        end
    endtask

    task automatic runStream(input logic [29:0] base, input int unsigned gap);
        logic [31:0] w;
        logic [29:0] a;
        for (int i = 0; i < bq.size(); i++) begin
            if ((i % 4) == 3) begin
                w = {bq[i-3], bq[i-2], bq[i-1], bq[i]};
                a = base + 30'(i / 4);
                sendByte(bq[i], gap, 1'b1, a, w);
            end else begin
                sendByte(bq[i], gap, 1'b0, '0, '0);
            end
        end
    endtask

    initial begin
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream, two words
        clearLogs();
        bq = '{8'h8C, 8'h08, 8'h00, 8'h00, 8'h21, 8'h09, 8'h00, 8'h05};
        startLoad(30'd0, 8'd2);
        check1("b2b cpu_hold", cpu_hold, 1'b1);
        check1("b2b byte_ready", byte_ready, 1'b1);
        runStream(30'd0, 0);
        tick();
        check1("b2b done", done, 1'b1);
        check1("b2b hold in DONE", cpu_hold, 1'b1);
        check("b2b checksum", {24'd0, checksum}, 32'h0000_00A9);
        tick();
        check1("b2b done low", done, 1'b0);
        check1("b2b hold low", cpu_hold, 1'b0);
        check("b2b checksum held", {24'd0, checksum}, 32'h0000_00A9);
        check("b2b writes", wrCount, 2);
        check("b2b done count", doneCount, 1);
        check("b2b addr0", {2'd0, wrAddrLog[0]}, 32'd0);
        check("b2b data0", wrDataLog[0], 32'h8C08_0000);
        check("b2b addr1", {2'd0, wrAddrLog[1]}, 32'd1);
        check("b2b data1", wrDataLog[1], 32'h2109_0005);

        // Same stream with idle cycles between bytes
        clearLogs();
        startLoad(30'd0, 8'd2);
        runStream(30'd0, 3);
        check("gap checksum", {24'd0, checksum}, 32'h0000_00A9);
        check("gap writes", wrCount, 2);
        check("gap done count", doneCount, 1);
        check("gap data0", wrDataLog[0], 32'h8C08_0000);
        check("gap data1", wrDataLog[1], 32'h2109_0005);

        // Zero-length load
        clearLogs();
        startLoad(30'h55, 8'd0);
        check1("len0 done", done, 1'b1);
        check1("len0 cpu_hold", cpu_hold, 1'b1);
        check1("len0 byte_ready", byte_ready, 1'b0);
        check1("len0 writeINS", writeINS, 1'b0);
        check("len0 checksum", {24'd0, checksum}, 32'd0);
        tick();
        check1("len0 done low", done, 1'b0);
        check1("len0 hold low", cpu_hold, 1'b0);
        check("len0 writes", wrCount, 0);
        check("len0 done count", doneCount, 1);

        // Address wrap, plus a start issued mid-load
        clearLogs();
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        startLoad(30'h3FFF_FFFF, 8'd2);
        base_addr = 30'd5;
        length = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("busy start done", done, 1'b0);
        check1("busy start hold", cpu_hold, 1'b1);
        check1("busy start ready", byte_ready, 1'b1);
        runStream(30'h3FFF_FFFF, 1);
        tick();
        tick();
        check("wrap addr0", {2'd0, wrAddrLog[0]}, 32'h3FFF_FFFF);
        check("wrap addr1", {2'd0, wrAddrLog[1]}, 32'd0);
        check("wrap data0", wrDataLog[0], 32'h0102_0304);
        check("wrap data1", wrDataLog[1], 32'h0506_0708);
        check("wrap checksum", {24'd0, checksum}, 32'h0000_0008);
        check("wrap done count", doneCount, 1);

        // Abort after two bytes of the second word, byte offered alongside abort
        clearLogs();
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        startLoad(30'h100, 8'd2);
        runStream(30'h100, 0);
        sendByte(8'h12, 0, 1'b0, '0, '0);
        sendByte(8'h34, 0, 1'b0, '0, '0);
        byte_valid = 1'b1;
        byte_data = 8'h56;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        byte_valid = 1'b0;
        check1("abort byte_ready", byte_ready, 1'b0);
        check1("abort cpu_hold", cpu_hold, 1'b0);
        check1("abort writeINS", writeINS, 1'b0);
        check1("abort done", done, 1'b0);
        check("abort checksum", {24'd0, checksum}, 32'h0000_0062);
        repeat (4) tick();
        check("abort writes", wrCount, 1);
        check("abort done count", doneCount, 0);
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        startLoad(30'h20, 8'd1);
        runStream(30'h20, 0);
        tick();
        check1("reload done", done, 1'b1);
        check("reload checksum", {24'd0, checksum}, 32'h0000_0022);
        tick();
        check("reload writes", wrCount, 2);
        check("reload addr", {2'd0, wrAddrLog[1]}, 32'h20);
        check("reload data", wrDataLog[1], 32'hDEAD_BEEF);
        check("reload done count", doneCount, 1);

        // Length above memory depth is clamped to 128 words
        clearLogs();
        bq.delete();
        for (int i = 0; i < 512; i++) bq.push_back(8'(i));
        startLoad(30'h1000, 8'd200);
        runStream(30'h1000, 0);
        tick();
        check1("clamp done", done, 1'b1);
        check("clamp writes", wrCount, 128);
        check("clamp checksum", {24'd0, checksum}, 32'd0);
        check("clamp last addr", {2'd0, wrAddrLog[127]}, 32'h107F);
        tick();
        check1("clamp hold low", cpu_hold, 1'b0);
        check("clamp done count", doneCount, 1);

        // Reset mid-word with byte_valid held high
        clearLogs();
        startLoad(30'd0, 8'd1);
        sendByte(8'hAA, 0, 1'b0, '0, '0);
        sendByte(8'hBB, 0, 1'b0, '0, '0);
        byte_valid = 1'b1;
        byte_data = 8'hCC;
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check1("post-reset writeINS", writeINS, 1'b0);
            check1("post-reset byte_ready", byte_ready, 1'b0);
        end
        byte_valid = 1'b0;
        check1("post-reset cpu_hold", cpu_hold, 1'b0);
        check("post-reset writes", wrCount, 0);
        check("post-reset done count", doneCount, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
